// File: rtl/data_cache_if.sv
// Bundle of the pipeline-side request/response and the backing-memory handshake.
// The cache is the slave; the pipeline plus backing memory form the master side.
interface data_cache_if;
    logic        req_read;
    logic        req_write;
    logic        req_word;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output req_read, req_write, req_word, req_addr, req_wdata, mem_rdata, mem_ready,
        input  rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );

    modport slave (
        input  req_read, req_write, req_word, req_addr, req_wdata, mem_rdata, mem_ready,
        output rdata, stall, mem_req, mem_we, mem_addr, mem_wdata, mem_be
    );
endinterface

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache with a variable-latency
// backing memory. Loads hit in zero cycles; misses refill a whole line word by word.
module data_cache #(
    parameter int unsigned LINES          = 8,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    data_cache_if.slave bus
);
    localparam int unsigned OFF_W  = $clog2(4 * WORDS_PER_LINE);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = 32 - OFF_W - IDX_W;
    localparam int unsigned WSEL_W = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {StIdle, StRefill, StWrite} state_t;

    state_t              r_state;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tag  [LINES];
    logic [31:0]         r_data [LINES][WORDS_PER_LINE];
    logic [WSEL_W-1:0]   r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;
    logic [3:0]          r_mem_be;

    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_idx;
    logic [WSEL_W-1:0]   w_wsel;
    logic [1:0]          w_lane;
    logic                w_hit;
    logic                w_store;
    logic                w_load;
    logic                w_last;
    logic [31:0]         w_line_word;

    assign w_tag       = bus.req_addr[31 -: TAG_W];
    assign w_idx       = bus.req_addr[OFF_W +: IDX_W];
    assign w_wsel      = bus.req_addr[2 +: WSEL_W];
    assign w_lane      = bus.req_addr[1:0];
    assign w_hit       = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_store     = bus.req_write;
    assign w_load      = bus.req_read && !bus.req_write;
    assign w_last      = (r_cnt == WSEL_W'(WORDS_PER_LINE - 1));
    assign w_line_word = r_data[w_idx][w_wsel];

    assign bus.mem_req   = r_mem_req;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.mem_be    = r_mem_be;

    always_comb begin
        bus.rdata = '0;
        if (r_state == StIdle && w_load && w_hit) begin
            bus.rdata = bus.req_word ? w_line_word : {24'b0, w_line_word[{w_lane, 3'b000} +: 8]};
        end
    end

    // Stall releases in the WRITE ready cycle so the pipeline advances on that edge.
    always_comb begin
        bus.stall = 1'b0;
        unique case (r_state)
            StIdle:   bus.stall = w_store || (w_load && !w_hit);
            StRefill: bus.stall = 1'b1;
            StWrite:  bus.stall = !bus.mem_ready;
            default:  bus.stall = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_valid     <= '0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_store) begin
                        r_state     <= StWrite;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= {bus.req_addr[31:2], 2'b00};
                        r_mem_wdata <= bus.req_word ? bus.req_wdata : {4{bus.req_wdata[7:0]}};
                        r_mem_be    <= bus.req_word ? 4'b1111 : (4'b0001 << w_lane);
                    end else if (w_load && !w_hit) begin
                        // Line is invalid while partially overwritten.
                        r_state        <= StRefill;
                        r_cnt          <= '0;
                        r_valid[w_idx] <= 1'b0;
                        r_mem_req      <= 1'b1;
                        r_mem_we       <= 1'b0;
                        r_mem_be       <= 4'b1111;
                        r_mem_addr     <= {bus.req_addr[31:OFF_W], {OFF_W{1'b0}}};
                    end
                end
                StRefill: begin
                    if (bus.mem_ready) begin
                        if (w_last) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= StIdle;
                            r_mem_req      <= 1'b0;
                            r_cnt          <= '0;
                        end else begin
                            r_cnt      <= r_cnt + WSEL_W'(1);
                            r_mem_addr <= r_mem_addr + 32'd4;
                        end
                    end
                end
                StWrite: begin
                    if (bus.mem_ready) begin
                        r_state   <= StIdle;
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Data and tag arrays carry no reset; validity alone qualifies them.
    always_ff @(posedge i_clk) begin
        if (!i_reset && r_state == StRefill && bus.mem_ready) begin
            r_data[w_idx][r_cnt] <= bus.mem_rdata;
            if (w_last) begin
                r_tag[w_idx] <= w_tag;
            end
        end
        if (!i_reset && r_state == StWrite && bus.mem_ready && w_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (r_mem_be[b]) begin
                    r_data[w_idx][w_wsel][8*b +: 8] <= r_mem_wdata[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_data_cache.sv
// Randomized bench for data_cache: backing-memory responder with variable latency and a
// line-residency plus memory-image reference model.
module tb_data_cache;
    localparam int unsigned LINES      = 8;
    localparam int unsigned WPL        = 4;
    localparam int unsigned LINE_BYTES = 4 * WPL;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_cache_if bus();

    data_cache #(
        .LINES          (LINES),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory image; unwritten words hold an address-derived pattern.
    logic [31:0] mem_m [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] wa;
        wa = {a[31:2], 2'b00};
        if (mem_m.exists(wa)) return mem_m[wa];
        return {wa[15:0] ^ 16'hC3A5, wa[15:0]};
    endfunction

    // Which line base address each cache index currently holds.
    logic [31:0] res_base [LINES];
    bit          res_v    [LINES];

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a - (a % LINE_BYTES);
    endfunction

    function automatic bit model_hit(input logic [31:0] a);
        return res_v[idx_of(a)] && (res_base[idx_of(a)] == base_of(a));
    endfunction

    typedef struct packed {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    txn_t        txq[$];
    int          lat_fixed  = -1;
    int          wait_cnt   = 0;
    bit          first_seen = 1'b0;
    logic [31:0] first_addr = '0;

    function automatic int pick_lat();
        return (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
    endfunction

    initial begin
        bus.mem_ready = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_ready = 1'b0;
            if (reset || !bus.mem_req) begin
                wait_cnt   = pick_lat();
                first_seen = 1'b0;
            end else begin
                if (!first_seen) begin
                    first_addr = bus.mem_addr;
                    first_seen = 1'b1;
                end
                if (wait_cnt == 0) begin
                    txn_t        t;
                    logic [31:0] w;
                    check_eq("mem_addr_stable", bus.mem_addr, first_addr);
                    t.we    = bus.mem_we;
                    t.be    = bus.mem_be;
                    t.addr  = bus.mem_addr;
                    t.wdata = bus.mem_wdata;
                    txq.push_back(t);
                    w = mem_rd(bus.mem_addr);
                    if (bus.mem_we) begin
                        for (int b = 0; b < 4; b++) begin
                            if (bus.mem_be[b]) w[8*b +: 8] = bus.mem_wdata[8*b +: 8];
                        end
                        mem_m[{bus.mem_addr[31:2], 2'b00}] = w;
                    end
                    bus.mem_rdata = w;
                    bus.mem_ready = 1'b1;
                    wait_cnt      = pick_lat();
                    first_seen    = 1'b0;
                end else begin
                    wait_cnt--;
                end
            end
        end
    end

    task automatic idle_req();
        bus.req_read  = 1'b0;
        bus.req_write = 1'b0;
        bus.req_word  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic do_load(input logic [31:0] a, input bit word);
        bit          hit;
        logic [31:0] exp_w;
        logic [31:0] exp;
        int          cyc;
        hit   = model_hit(a);
        exp_w = mem_rd(a);
        exp   = word ? exp_w : ((exp_w >> (8 * a[1:0])) & 32'hFF);
        cyc   = 0;
        txq.delete();
        bus.req_read  = 1'b1;
        bus.req_write = 1'b0;
        bus.req_word  = word;
        bus.req_addr  = a;
        bus.req_wdata = $urandom;
        @(negedge clk); #1;
        if (bus.stall) check_eq("miss_rdata_zero", bus.rdata, 32'h0);
        if (hit) check_eq("hit_no_mem_req", {31'b0, bus.mem_req}, 32'h0);
        while (bus.stall && cyc < 200) begin
            cyc++;
            @(negedge clk); #1;
        end
        check_eq("load_zero_latency", {31'b0, cyc == 0}, {31'b0, hit});
        check_eq("load_rdata", bus.rdata, exp);
        check_eq("load_txn_count", txq.size(), hit ? 0 : WPL);
        if (!hit) begin
            for (int i = 0; i < txq.size() && i < WPL; i++) begin
                check_eq("refill_addr", txq[i].addr, base_of(a) + 4 * i);
                check_eq("refill_we", {31'b0, txq[i].we}, 32'h0);
            end
            res_v[idx_of(a)]    = 1'b1;
            res_base[idx_of(a)] = base_of(a);
        end
        @(posedge clk); #1;
        idle_req();
    endtask

    task automatic do_store(input logic [31:0] a, input bit word, input logic [31:0] d,
                            input bit also_read, input int lat);
        logic [3:0]  be;
        logic [31:0] mask;
        logic [31:0] exp_d;
        int          cyc;
        be    = word ? 4'hF : 4'(1 << a[1:0]);
        exp_d = word ? d : {4{d[7:0]}};
        for (int b = 0; b < 4; b++) mask[8*b +: 8] = {8{be[b]}};
        cyc       = 0;
        lat_fixed = lat;
        txq.delete();
        bus.req_read  = also_read;
        bus.req_write = 1'b1;
        bus.req_word  = word;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk); #1;
        check_eq("store_stall_first", {31'b0, bus.stall}, 32'h1);
        check_eq("store_rdata_zero", bus.rdata, 32'h0);
        while (bus.stall && cyc < 200) begin
            cyc++;
            @(negedge clk); #1;
        end
        check_eq("store_txn_count", txq.size(), 1);
        if (txq.size() >= 1) begin
            check_eq("store_addr", txq[0].addr, {a[31:2], 2'b00});
            check_eq("store_we", {31'b0, txq[0].we}, 32'h1);
            check_eq("store_be", {28'b0, txq[0].be}, {28'b0, be});
            check_eq("store_wdata", txq[0].wdata & mask, exp_d & mask);
        end
        if (lat >= 0) check_eq("store_latency", cyc, lat + 1);
        @(posedge clk); #1;
        idle_req();
        lat_fixed = -1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        idle_req();
        reset = 1'b1;
        for (int i = 0; i < LINES; i++) res_v[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check_eq("rst_stall", {31'b0, bus.stall}, 32'h0);
        check_eq("rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_eq("rst_mem_we", {31'b0, bus.mem_we}, 32'h0);
        check_eq("rst_rdata", bus.rdata, 32'h0);
        @(posedge clk); #1;

        do_load(32'h40, 1'b1);
        do_load(32'h44, 1'b1);
        do_store(32'h41, 1'b0, 32'h0000_00AB, 1'b0, 3);
        do_load(32'h41, 1'b0);
        do_store(32'h200, 1'b1, 32'hDEAD_BEEF, 1'b0, -1);
        do_load(32'h200, 1'b1);
        do_load(32'h40 + LINES * 16, 1'b1);
        do_load(32'h40, 1'b1);

        // Abandon a refill with reset once word 2 is being fetched.
        lat_fixed = 1;
        txq.delete();
        bus.req_read = 1'b1;
        bus.req_word = 1'b1;
        bus.req_addr = 32'h300;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (txq.size() < 2 && cyc < 100);
        check_eq("refill_reached_word2", txq.size(), 2);
        @(posedge clk); #1;
        reset = 1'b1;
        idle_req();
        @(posedge clk); #1;
        reset = 1'b0;
        lat_fixed = -1;
        @(negedge clk); #1;
        check_eq("mid_rst_mem_req", {31'b0, bus.mem_req}, 32'h0);
        check_eq("mid_rst_stall", {31'b0, bus.stall}, 32'h0);
        for (int i = 0; i < LINES; i++) res_v[i] = 1'b0;
        @(posedge clk); #1;
        do_load(32'h40, 1'b1);
        do_load(32'h300, 1'b0);

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 2) begin
                do_store(a, 1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0), -1);
            end else begin
                do_load(a, 1'($urandom_range(0, 1)));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
